dram_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous RAM (DRAM or IRAM) between three cores. It sits between the cores' Mem_Ctrl/address/data outputs and the RAM port. It grants exclusive ownership via a one-hot `acq` vector, muxes the owner's access onto the RAM, and routes read data back to the issuing core with a valid strobe. In-flight reads are tracked by owner tag, so ownership can change while reads are still outstanding.

---
 rtl/dram_rr_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dram_rr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_rr_arbiter.sv
// Round-robin owner of one single-port RAM shared by three cores, with owner-tagged read return.
// Define ARB_HOLD_LIMIT_EN to revoke a grant after HOLD_MAX cycles while another core waits.
module dram_rr_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int RD_LAT   = 2,
  parameter int HOLD_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      rden,
  input  logic [2:0]      wren,
  input  logic [3*AW-1:0] Address,
  input  logic [3*DW-1:0] Din,
  input  logic [DW-1:0]   RAMq,
  output logic [2:0]      acq,
  output logic [3*DW-1:0] Dq,
  output logic [2:0]      dvalid,
  output logic [AW-1:0]   RAMAddress,
  output logic [DW-1:0]   RAMDin,
  output logic            RAMwren
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      last_q, last_d;
  logic [2:0]      acq_q, acq_d;
  logic [2:0]      req;
  logic [1:0]      cand1, cand2;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_din;
  logic            own_rd, own_wr, own_req, own_now, launch;
  logic            others_req, hold_hit;

  logic [RD_LAT-1:0] pv_q;
  logic [1:0]        pid_q [RD_LAT];
  logic [2:0]        dvalid_q;
  logic [3*DW-1:0]   dq_q;

  function automatic logic [1:0] next_core(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  assign req        = rden | wren;
  assign others_req = |(req & ~acq_q);

  always_comb begin
    own_addr = '0;
    own_din  = '0;
    own_rd   = 1'b0;
    own_wr   = 1'b0;
    case (owner_q)
      2'd0: begin
        own_addr = Address[0 +: AW];
        own_din  = Din[0 +: DW];
        own_rd   = rden[0];
        own_wr   = wren[0];
      end
      2'd1: begin
        own_addr = Address[AW +: AW];
        own_din  = Din[DW +: DW];
        own_rd   = rden[1];
        own_wr   = wren[1];
      end
      default: begin
        own_addr = Address[2*AW +: AW];
        own_din  = Din[2*DW +: DW];
        own_rd   = rden[2];
        own_wr   = wren[2];
      end
    endcase
  end

  assign own_req = own_rd | own_wr;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter saturates at the revoke threshold so a lone owner keeps its grant.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (cnt_q != CW'(HOLD_MAX - 1)) cnt_d = cnt_q + 1'b1;
  end

  assign hold_hit = (cnt_q == CW'(HOLD_MAX - 1)) && others_req;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam int unused_hold_max = HOLD_MAX;
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    acq_d   = acq_q;
    cand1   = next_core(last_q);
    cand2   = next_core(cand1);
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          if (req[cand1])      owner_d = cand1;
          else if (req[cand2]) owner_d = cand2;
          else                 owner_d = last_q;
          last_d = owner_d;
          acq_d  = 3'b001 << owner_d;
        end
      end
      OWN: begin
        if (!own_req || hold_hit) begin
          state_d = IDLE;
          acq_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acq_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      acq_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      acq_q   <= acq_d;
    end
  end

  // A simultaneous write and read from the owner is treated as a write only.
  assign own_now    = (state_q == OWN) && !rst;
  assign RAMwren    = own_now && own_wr;
  assign RAMAddress = own_now ? own_addr : '0;
  assign RAMDin     = own_now ? own_din : '0;
  assign launch     = own_now && own_rd && !own_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pid_q[i] <= 2'd0;
    end else begin
      pv_q[0]  <= launch;
      pid_q[0] <= owner_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvalid_q <= '0;
      dq_q     <= '0;
    end else begin
      dvalid_q <= '0;
      if (pv_q[RD_LAT-1]) begin
        dvalid_q <= 3'b001 << pid_q[RD_LAT-1];
        for (int c = 0; c < 3; c++) begin
          if (pid_q[RD_LAT-1] == 2'(c)) dq_q[c*DW +: DW] <= RAMq;
        end
      end
    end
  end

  assign acq    = acq_q;
  assign dvalid = dvalid_q;
  assign Dq     = dq_q;

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Bench for dram_rr_arbiter: hand-derived vector table, directed read/reset/hold sequences,
// and randomized traffic against a queue-based reference model.
module tb_dram_rr_arbiter;
  localparam int AW = 8, DW = 8, RD_LAT = 2, HOLD_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    rden, wren;
  logic [3*AW-1:0] Address;
  logic [3*DW-1:0] Din;
  logic [DW-1:0] RAMq;
  logic [2:0]    acq, dvalid;
  logic [3*DW-1:0] Dq;
  logic [AW-1:0] RAMAddress;
  logic [DW-1:0] RAMDin;
  logic          RAMwren;

  always #5 clk = ~clk;

  dram_rr_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .rden(rden), .wren(wren), .Address(Address), .Din(Din),
    .RAMq(RAMq), .acq(acq), .Dq(Dq), .dvalid(dvalid), .RAMAddress(RAMAddress),
    .RAMDin(RAMDin), .RAMwren(RAMwren)
  );

  // RAM with RD_LAT cycles from sampling edge to valid data
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_pipe [RD_LAT];
  always @(posedge clk) begin
    if (RAMwren) ram[RAMAddress] <= RAMDin;
    ram_pipe[0] <= ram[RAMAddress];
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign RAMq = ram_pipe[RD_LAT-1];

  typedef struct { int due; int id; logic [DW-1:0] data; } pend_t;
  pend_t         pend[$];
  bit            m_own;
  int            m_owner, m_last, m_cnt, cyc;
  logic [2:0]    m_acq, m_dvalid;
  logic [DW-1:0] m_dq [3];
  logic [DW-1:0] ref_mem [256];
  int            checks, failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [2:0] r;
    int o, a;
    cyc++;
    r = rden | wren;
    if (rst) begin
      m_own = 0; m_last = 2; m_cnt = 0; m_acq = '0; m_dvalid = '0;
      for (int c = 0; c < 3; c++) m_dq[c] = '0;
      pend.delete();
      return;
    end
    m_dvalid = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      m_dq[pend[0].id] = pend[0].data;
      m_dvalid[pend[0].id] = 1'b1;
      void'(pend.pop_front());
    end
    if (m_own) begin
      o = m_owner;
      a = int'(Address[o*AW +: AW]);
      if (wren[o]) ref_mem[a] = Din[o*DW +: DW];
      else if (rden[o]) pend.push_back('{cyc + RD_LAT, o, ref_mem[a]});
      m_cnt++;
      if (!r[o]) m_own = 0;
`ifdef ARB_HOLD_LIMIT_EN
      else if (m_cnt >= HOLD_MAX && (r & ~(3'b001 << o)) != 3'b000) m_own = 0;
`endif
    end else begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (!m_own && r[c]) begin
          m_own = 1; m_owner = c; m_last = c; m_cnt = 0;
        end
      end
    end
    m_acq = m_own ? 3'(1 << m_owner) : 3'b000;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/acq"}, 32'(acq), 32'(m_acq));
    chk({tag, "/dvalid"}, 32'(dvalid), 32'(m_dvalid));
    for (int c = 0; c < 3; c++)
      chk($sformatf("%s/dq%0d", tag, c), 32'(Dq[c*DW +: DW]), 32'(m_dq[c]));
    chk({tag, "/ramwren"}, 32'(RAMwren), 32'(m_own && wren[m_owner] && !rst));
    chk({tag, "/ramaddr"}, 32'(RAMAddress), m_own ? 32'(Address[m_owner*AW +: AW]) : 32'd0);
    chk({tag, "/ramdin"}, 32'(RAMDin), m_own ? 32'(Din[m_owner*DW +: DW]) : 32'd0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] rd, wr, exp_acq;
    logic       exp_wren;
    logic [7:0] exp_addr, exp_din;
    logic [2:0] exp_dvalid;
  } vec_t;
  vec_t tbl [12];

  initial begin
    checks = 0; failures = 0; cyc = 0;
    m_own = 0; m_owner = 0; m_last = 2; m_cnt = 0; m_acq = '0; m_dvalid = '0;
    for (int c = 0; c < 3; c++) m_dq[c] = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] <= 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    rst = 1'b1; rden = '0; wren = '0;
    Address = {8'h30, 8'h20, 8'h10};
    Din     = {8'hC3, 8'hB2, 8'hA5};

    // rst rd wr acq wren addr din dvalid
    tbl[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 3'b000};
    tbl[1]  = '{1'b0, 3'b000, 3'b111, 3'b001, 1'b1, 8'h10, 8'hA5, 3'b000};
    tbl[2]  = '{1'b0, 3'b000, 3'b111, 3'b001, 1'b1, 8'h10, 8'hA5, 3'b000};
    tbl[3]  = '{1'b0, 3'b000, 3'b110, 3'b000, 1'b0, 8'h00, 8'h00, 3'b000};
    tbl[4]  = '{1'b0, 3'b000, 3'b110, 3'b010, 1'b1, 8'h20, 8'hB2, 3'b000};
    tbl[5]  = '{1'b0, 3'b000, 3'b110, 3'b010, 1'b1, 8'h20, 8'hB2, 3'b000};
    tbl[6]  = '{1'b0, 3'b000, 3'b100, 3'b000, 1'b0, 8'h00, 8'h00, 3'b000};
    tbl[7]  = '{1'b0, 3'b000, 3'b100, 3'b100, 1'b1, 8'h30, 8'hC3, 3'b000};
    tbl[8]  = '{1'b0, 3'b000, 3'b100, 3'b100, 1'b1, 8'h30, 8'hC3, 3'b000};
    tbl[9]  = '{1'b0, 3'b000, 3'b001, 3'b000, 1'b0, 8'h00, 8'h00, 3'b000};
    tbl[10] = '{1'b0, 3'b000, 3'b001, 3'b001, 1'b1, 8'h10, 8'hA5, 3'b000};
    tbl[11] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 3'b000};

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; rden = tbl[i].rd; wren = tbl[i].wr;
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d/acq", i), 32'(acq), 32'(tbl[i].exp_acq));
      chk($sformatf("vec%0d/wren", i), 32'(RAMwren), 32'(tbl[i].exp_wren));
      chk($sformatf("vec%0d/addr", i), 32'(RAMAddress), 32'(tbl[i].exp_addr));
      chk($sformatf("vec%0d/din", i), 32'(RAMDin), 32'(tbl[i].exp_din));
      chk($sformatf("vec%0d/dvalid", i), 32'(dvalid), 32'(tbl[i].exp_dvalid));
    end

    // Core 1 reads 0x10, which core 0 wrote with 0xA5
    Address[15:8] = 8'h10;
    rden = 3'b010;
    tick("rd1_grant");   chk("rd1_grant/acq", 32'(acq), 32'h2);
    tick("rd1_launch");  chk("rd1_launch/dvalid", 32'(dvalid), 32'h0);
    rden = 3'b000;
    for (int i = 1; i < RD_LAT; i++) begin
      tick("rd1_wait");  chk("rd1_wait/dvalid", 32'(dvalid), 32'h0);
    end
    tick("rd1_data");
    chk("rd1_data/dvalid", 32'(dvalid), 32'h2);
    chk("rd1_data/dq1", 32'(Dq[15:8]), 32'hA5);
    chk("rd1_data/dq0", 32'(Dq[7:0]), 32'h0);
    chk("rd1_data/dq2", 32'(Dq[23:16]), 32'h0);
    tick("rd1_sticky");
    chk("rd1_sticky/dvalid", 32'(dvalid), 32'h0);
    chk("rd1_sticky/dq1", 32'(Dq[15:8]), 32'hA5);

    // Core 2 reads 0x30 then releases while core 0 waits
    rden = 3'b101;
    tick("rd2_grant");   chk("rd2_grant/acq", 32'(acq), 32'h4);
    tick("rd2_launch");  chk("rd2_launch/acq", 32'(acq), 32'h4);
    rden = 3'b001;
    tick("rd2_bubble");  chk("rd2_bubble/acq", 32'(acq), 32'h0);
    tick("rd2_data");
    chk("rd2_data/acq", 32'(acq), 32'h1);
    chk("rd2_data/dvalid", 32'(dvalid), 32'h4);
    chk("rd2_data/dq2", 32'(Dq[23:16]), 32'hC3);

    // Core 0 read cut off by reset
    tick("rst_launch");  chk("rst_launch/acq", 32'(acq), 32'h1);
    rst = 1'b1; rden = 3'b000;
    tick("rst_hit");
    chk("rst_hit/acq", 32'(acq), 32'h0);
    chk("rst_hit/dq", 32'(Dq), 32'h0);
    chk("rst_hit/dvalid", 32'(dvalid), 32'h0);
    chk("rst_hit/wren", 32'(RAMwren), 32'h0);
    chk("rst_hit/addr", 32'(RAMAddress), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < RD_LAT + 1; i++) begin
      tick("rst_after"); chk("rst_after/dvalid", 32'(dvalid), 32'h0);
    end

    // Core 0 holds while core 1 waits
    wren = 3'b011;
    tick("hold_grant");  chk("hold_grant/acq", 32'(acq), 32'h1);
    for (int i = 1; i < HOLD_MAX; i++) begin
      tick("hold_own");  chk("hold_own/acq", 32'(acq), 32'h1);
    end
`ifdef ARB_HOLD_LIMIT_EN
    tick("hold_revoke"); chk("hold_revoke/acq", 32'(acq), 32'h0);
    tick("hold_next");   chk("hold_next/acq", 32'(acq), 32'h2);
`else
    for (int i = 0; i < 8; i++) begin
      tick("hold_keep"); chk("hold_keep/acq", 32'(acq), 32'h1);
    end
`endif
    wren = 3'b000;
    tick("hold_end");
    tick("hold_end");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          rden[c] = $urandom_range(0, 1) == 1;
          wren[c] = $urandom_range(0, 2) == 0;
        end
        Address[c*AW +: AW] = 8'($urandom_range(0, 15));
        Din[c*DW +: DW]     = 8'($urandom);
      end
      tick("rand");
    end
    rst = 1'b0; rden = '0; wren = '0;
    for (int i = 0; i < RD_LAT + 2; i++) tick("drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
